// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcode encodings, data widths, entry payload layout.
package alu_rs_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CODE_W    = 6;
    localparam int unsigned ROB_W_DEF = 32;

    typedef enum logic [CODE_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADDI  = 6'd19,
        OP_SLTI  = 6'd20,
        OP_SLTIU = 6'd21,
        OP_XORI  = 6'd22,
        OP_ORI   = 6'd23,
        OP_ANDI  = 6'd24,
        OP_SLLI  = 6'd25,
        OP_SRLI  = 6'd26,
        OP_SRAI  = 6'd27,
        OP_ADD   = 6'd28,
        OP_SUB   = 6'd29,
        OP_SLL   = 6'd30,
        OP_SLT   = 6'd31,
        OP_SLTU  = 6'd32,
        OP_XOR   = 6'd33,
        OP_SRL   = 6'd34,
        OP_SRA   = 6'd35,
        OP_OR    = 6'd36,
        OP_AND   = 6'd37
    } opcode_t;

    // Tag-width-independent part of an entry; Q tags and rob id live beside it.
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              r1;
        logic              r2;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] pc;
    } rs_data_t;

endpackage

// File: rtl/alu_rs_select.sv
// One-hot picker: lowest-index candidate, or oldest candidate via age matrix when ALU_RS_AGE_SELECT_EN is defined.
module rs_select
    import alu_rs_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]        cand,
`ifdef ALU_RS_AGE_SELECT_EN
    input  logic [N-1:0][N-1:0] age,
`endif
    output logic [N-1:0]        gnt,
    output logic                vld
);

    // age[j][i]=1 means j is older than i; an all-zero matrix degrades to lowest index.
    always_comb begin
        vld = |cand;
        gnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            gnt[i] = cand[i];
            for (int unsigned j = 0; j < N; j++) begin
`ifdef ALU_RS_AGE_SELECT_EN
                if (j != i && cand[j] && (age[j][i] || (j < i && !age[i][j])))
                    gnt[i] = 1'b0;
`else
                if (j < i && cand[j])
                    gnt[i] = 1'b0;
`endif
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops ex/lsb CDBs, issues one ready op per cycle.
// Define ALU_RS_AGE_SELECT_EN for oldest-first issue; otherwise lowest-index-first.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned NUM_ENTRY = 8,
    parameter int unsigned ROB_W     = ROB_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear,
    input  logic              dsp_flag,
    input  logic [5:0]        dsp_inst_code,
    input  logic              dsp_R1,
    input  logic              dsp_R2,
    input  logic [31:0]       dsp_V1,
    input  logic [31:0]       dsp_V2,
    input  logic [ROB_W-1:0]  dsp_Q1,
    input  logic [ROB_W-1:0]  dsp_Q2,
    input  logic [31:0]       dsp_A,
    input  logic [31:0]       dsp_pc,
    input  logic [ROB_W-1:0]  dsp_rob_id,
    output logic              rs_full,
    input  logic              ex_cdb_flag,
    input  logic [ROB_W-1:0]  ex_cdb_rob_id,
    input  logic [31:0]       ex_cdb_val,
    input  logic              lsb_cdb_flag,
    input  logic [ROB_W-1:0]  lsb_cdb_rob_id,
    input  logic [31:0]       lsb_cdb_val,
    output logic              RS_flag,
    output logic [31:0]       RS_V1,
    output logic [31:0]       RS_V2,
    output logic [31:0]       RS_A,
    output logic [31:0]       RS_inst_pc,
    output logic [5:0]        RS_inst_code,
    output logic [ROB_W-1:0]  RS_inst_rob_id
);

    logic [NUM_ENTRY-1:0] busy;
    rs_data_t             ent [NUM_ENTRY];
    logic [ROB_W-1:0]     q1  [NUM_ENTRY];
    logic [ROB_W-1:0]     q2  [NUM_ENTRY];
    logic [ROB_W-1:0]     rob [NUM_ENTRY];
    logic                 flag_q;

    logic [NUM_ENTRY-1:0] cand, free_gnt, iss_gnt;
    logic                 free_vld, iss_vld;
    rs_data_t             iss_data, new_data;
    logic [ROB_W-1:0]     iss_rob;

    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRY; i++)
            cand[i] = busy[i] & ent[i].r1 & ent[i].r2;
    end

    assign rs_full = &busy;
    assign RS_flag = flag_q & rdy_in;

`ifdef ALU_RS_AGE_SELECT_EN
    logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] age;

    rs_select #(.N(NUM_ENTRY)) u_free_sel (
        .cand (~busy),
        .age  ('0),
        .gnt  (free_gnt),
        .vld  (free_vld)
    );

    rs_select #(.N(NUM_ENTRY)) u_issue_sel (
        .cand (cand),
        .age  (age),
        .gnt  (iss_gnt),
        .vld  (iss_vld)
    );
`else
    rs_select #(.N(NUM_ENTRY)) u_free_sel (
        .cand (~busy),
        .gnt  (free_gnt),
        .vld  (free_vld)
    );

    rs_select #(.N(NUM_ENTRY)) u_issue_sel (
        .cand (cand),
        .gnt  (iss_gnt),
        .vld  (iss_vld)
    );
`endif

    always_comb begin
        iss_data = '0;
        iss_rob  = '0;
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            if (iss_gnt[i]) begin
                iss_data = ent[i];
                iss_rob  = rob[i];
            end
        end
    end

    // Dispatch payload with same-cycle CDB forwarding; ex_cdb wins on a duplicate tag.
    always_comb begin
        new_data.code = dsp_inst_code;
        new_data.a    = dsp_A;
        new_data.pc   = dsp_pc;
        new_data.r1   = dsp_R1;
        new_data.v1   = dsp_V1;
        new_data.r2   = dsp_R2;
        new_data.v2   = dsp_V2;
        if (!dsp_R1) begin
            if (ex_cdb_flag && ex_cdb_rob_id == dsp_Q1) begin
                new_data.r1 = 1'b1;
                new_data.v1 = ex_cdb_val;
            end else if (lsb_cdb_flag && lsb_cdb_rob_id == dsp_Q1) begin
                new_data.r1 = 1'b1;
                new_data.v1 = lsb_cdb_val;
            end
        end
        if (!dsp_R2) begin
            if (ex_cdb_flag && ex_cdb_rob_id == dsp_Q2) begin
                new_data.r2 = 1'b1;
                new_data.v2 = ex_cdb_val;
            end else if (lsb_cdb_flag && lsb_cdb_rob_id == dsp_Q2) begin
                new_data.r2 = 1'b1;
                new_data.v2 = lsb_cdb_val;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy           <= '0;
            flag_q         <= 1'b0;
            RS_V1          <= '0;
            RS_V2          <= '0;
            RS_A           <= '0;
            RS_inst_pc     <= '0;
            RS_inst_code   <= '0;
            RS_inst_rob_id <= '0;
            for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
                ent[i] <= '0;
                q1[i]  <= '0;
                q2[i]  <= '0;
                rob[i] <= '0;
            end
`ifdef ALU_RS_AGE_SELECT_EN
            age <= '0;
`endif
        end else if (!rdy_in) begin
            flag_q <= 1'b0;
        end else if (rob_clear) begin
            busy   <= '0;
            flag_q <= 1'b0;
`ifdef ALU_RS_AGE_SELECT_EN
            age <= '0;
`endif
        end else begin
            flag_q <= iss_vld;
            if (iss_vld) begin
                RS_V1          <= iss_data.v1;
                RS_V2          <= iss_data.v2;
                RS_A           <= iss_data.a;
                RS_inst_pc     <= iss_data.pc;
                RS_inst_code   <= iss_data.code;
                RS_inst_rob_id <= iss_rob;
            end
            for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
                if (busy[i] && !ent[i].r1) begin
                    if (ex_cdb_flag && ex_cdb_rob_id == q1[i]) begin
                        ent[i].r1 <= 1'b1;
                        ent[i].v1 <= ex_cdb_val;
                    end else if (lsb_cdb_flag && lsb_cdb_rob_id == q1[i]) begin
                        ent[i].r1 <= 1'b1;
                        ent[i].v1 <= lsb_cdb_val;
                    end
                end
                if (busy[i] && !ent[i].r2) begin
                    if (ex_cdb_flag && ex_cdb_rob_id == q2[i]) begin
                        ent[i].r2 <= 1'b1;
                        ent[i].v2 <= ex_cdb_val;
                    end else if (lsb_cdb_flag && lsb_cdb_rob_id == q2[i]) begin
                        ent[i].r2 <= 1'b1;
                        ent[i].v2 <= lsb_cdb_val;
                    end
                end
                if (iss_gnt[i]) begin
                    busy[i] <= 1'b0;
`ifdef ALU_RS_AGE_SELECT_EN
                    age[i] <= '0;
                    for (int unsigned j = 0; j < NUM_ENTRY; j++)
                        age[j][i] <= 1'b0;
`endif
                end
                // Free slot is chosen from the start-of-cycle busy vector, so it never aliases the issued slot.
                if (dsp_flag && free_gnt[i]) begin
                    busy[i] <= 1'b1;
                    ent[i]  <= new_data;
                    q1[i]   <= dsp_Q1;
                    q2[i]   <= dsp_Q2;
                    rob[i]  <= dsp_rob_id;
`ifdef ALU_RS_AGE_SELECT_EN
                    age[i] <= '0;
                    for (int unsigned j = 0; j < NUM_ENTRY; j++)
                        age[j][i] <= busy[j] & ~iss_gnt[j];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs; issue-order expectations follow ALU_RS_AGE_SELECT_EN.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear, dsp_flag;
    logic [5:0]  dsp_inst_code;
    logic        dsp_R1, dsp_R2;
    logic [31:0] dsp_V1, dsp_V2, dsp_Q1, dsp_Q2, dsp_A, dsp_pc, dsp_rob_id;
    logic        rs_full;
    logic        ex_cdb_flag, lsb_cdb_flag;
    logic [31:0] ex_cdb_rob_id, ex_cdb_val, lsb_cdb_rob_id, lsb_cdb_val;
    logic        RS_flag;
    logic [31:0] RS_V1, RS_V2, RS_A, RS_inst_pc, RS_inst_rob_id;
    logic [5:0]  RS_inst_code;

    int checks = 0;
    int errors = 0;

    alu_rs #(.NUM_ENTRY(8), .ROB_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .dsp_flag(dsp_flag), .dsp_inst_code(dsp_inst_code),
        .dsp_R1(dsp_R1), .dsp_R2(dsp_R2), .dsp_V1(dsp_V1), .dsp_V2(dsp_V2),
        .dsp_Q1(dsp_Q1), .dsp_Q2(dsp_Q2), .dsp_A(dsp_A), .dsp_pc(dsp_pc),
        .dsp_rob_id(dsp_rob_id), .rs_full(rs_full),
        .ex_cdb_flag(ex_cdb_flag), .ex_cdb_rob_id(ex_cdb_rob_id), .ex_cdb_val(ex_cdb_val),
        .lsb_cdb_flag(lsb_cdb_flag), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_val(lsb_cdb_val),
        .RS_flag(RS_flag), .RS_V1(RS_V1), .RS_V2(RS_V2), .RS_A(RS_A),
        .RS_inst_pc(RS_inst_pc), .RS_inst_code(RS_inst_code), .RS_inst_rob_id(RS_inst_rob_id)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rob_clear = 0; dsp_flag = 0; dsp_inst_code = '0;
        dsp_R1 = 0; dsp_R2 = 0; dsp_V1 = '0; dsp_V2 = '0; dsp_Q1 = '0; dsp_Q2 = '0;
        dsp_A = '0; dsp_pc = '0; dsp_rob_id = '0;
        ex_cdb_flag = 0; ex_cdb_rob_id = '0; ex_cdb_val = '0;
        lsb_cdb_flag = 0; lsb_cdb_rob_id = '0; lsb_cdb_val = '0;
    endtask

    task automatic set_dsp(input opcode_t code, input logic r1, input logic [31:0] v1, input logic [31:0] q1,
                           input logic r2, input logic [31:0] v2, input logic [31:0] a, input logic [31:0] rob);
        dsp_flag = 1; dsp_inst_code = code;
        dsp_R1 = r1; dsp_V1 = v1; dsp_Q1 = q1;
        dsp_R2 = r2; dsp_V2 = v2; dsp_Q2 = '0;
        dsp_A = a; dsp_pc = 32'h1000 + rob; dsp_rob_id = rob;
    endtask

    task automatic test_reset();
        idle(); rdy_in = 1; rst_in = 1;
        tick(); tick();
        checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got=%0b exp=0", RS_flag); end
        checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", rs_full); end
        checks++; if (RS_V1 !== 32'd0 || RS_inst_rob_id !== 32'd0 || RS_inst_code !== 6'd0)
            begin errors++; $display("FAIL reset_data got v1=%0d rob=%0d code=%0d exp 0", RS_V1, RS_inst_rob_id, RS_inst_code); end
        rst_in = 0;
        tick();
    endtask

    task automatic test_basic();
        set_dsp(OP_ADDI, 1, 5, 0, 1, 0, 3, 2);
        tick(); idle();
        checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL basic_early got=%0b exp=0", RS_flag); end
        tick();
        checks++; if (RS_flag !== 1'b1 || RS_inst_code !== OP_ADDI || RS_V1 !== 32'd5 || RS_A !== 32'd3 || RS_inst_rob_id !== 32'd2 || RS_inst_pc !== 32'h1002)
            begin errors++; $display("FAIL basic_issue got flag=%0b code=%0d v1=%0d a=%0d rob=%0d pc=%h exp 1/%0d/5/3/2/1002",
                                     RS_flag, RS_inst_code, RS_V1, RS_A, RS_inst_rob_id, RS_inst_pc, OP_ADDI); end
        tick();
        checks++; if (RS_flag !== 1'b0 || RS_V1 !== 32'd5 || RS_inst_rob_id !== 32'd2)
            begin errors++; $display("FAIL basic_hold got flag=%0b v1=%0d rob=%0d exp 0/5/2", RS_flag, RS_V1, RS_inst_rob_id); end
    endtask

    task automatic test_wakeup();
        set_dsp(OP_ADD, 0, 0, 4, 1, 7, 0, 5);
        tick(); idle();
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL wake_wait%0d got=%0b exp=0", c, RS_flag); end
        end
        ex_cdb_flag = 1; ex_cdb_rob_id = 4; ex_cdb_val = 10;
        tick(); idle();
        checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL wake_same got=%0b exp=0", RS_flag); end
        tick();
        checks++; if (RS_flag !== 1'b1 || RS_V1 !== 32'd10 || RS_V2 !== 32'd7 || RS_inst_rob_id !== 32'd5)
            begin errors++; $display("FAIL wake_issue got flag=%0b v1=%0d v2=%0d rob=%0d exp 1/10/7/5", RS_flag, RS_V1, RS_V2, RS_inst_rob_id); end
        tick();
    endtask

    task automatic test_forward();
        set_dsp(OP_ADD, 0, 0, 4, 1, 1, 0, 6);
        ex_cdb_flag = 1; ex_cdb_rob_id = 4; ex_cdb_val = 9;
        tick(); idle();
        checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL fwd_early got=%0b exp=0", RS_flag); end
        tick();
        checks++; if (RS_flag !== 1'b1 || RS_V1 !== 32'd9 || RS_inst_rob_id !== 32'd6)
            begin errors++; $display("FAIL fwd_issue got flag=%0b v1=%0d rob=%0d exp 1/9/6", RS_flag, RS_V1, RS_inst_rob_id); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            set_dsp(OP_SUB, 0, 0, 9, 1, i, 0, 20 + i);
            tick();
            if (i == 6) begin
                checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL full_seven got=%0b exp=0", rs_full); end
            end
        end
        idle();
        checks++; if (rs_full !== 1'b1) begin errors++; $display("FAIL full_eight got=%0b exp=1", rs_full); end
        lsb_cdb_flag = 1; lsb_cdb_rob_id = 9; lsb_cdb_val = 100;
        tick(); idle();
        checks++; if (RS_flag !== 1'b0 || rs_full !== 1'b1) begin errors++; $display("FAIL full_wake got flag=%0b full=%0b exp 0/1", RS_flag, rs_full); end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (RS_flag !== 1'b1 || RS_inst_rob_id !== 32'(20 + k) || RS_V1 !== 32'd100 || RS_V2 !== 32'(k))
                begin errors++; $display("FAIL full_drain%0d got flag=%0b rob=%0d v1=%0d v2=%0d exp 1/%0d/100/%0d", k, RS_flag, RS_inst_rob_id, RS_V1, RS_V2, 20 + k, k); end
            if (k == 0) begin
                checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL full_drop got=%0b exp=0", rs_full); end
            end
        end
        tick();
        checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL full_empty got=%0b exp=0", RS_flag); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            set_dsp(OP_XOR, 0, 0, 11, 1, 0, 0, 40 + i);
            tick();
        end
        set_dsp(OP_ADDI, 1, 1, 0, 1, 0, 0, 45);
        rob_clear = 1;
        tick(); idle();
        checks++; if (RS_flag !== 1'b0 || rs_full !== 1'b0) begin errors++; $display("FAIL flush_now got flag=%0b full=%0b exp 0/0", RS_flag, rs_full); end
        tick();
        checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%0b exp=0", RS_flag); end
        ex_cdb_flag = 1; ex_cdb_rob_id = 11; ex_cdb_val = 3;
        tick(); idle(); tick();
        checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL flush_gone got=%0b exp=0", RS_flag); end
        for (int i = 0; i < 8; i++) begin
            set_dsp(OP_OR, 0, 0, 12, 1, 0, 0, 50 + i);
            tick();
        end
        idle();
        checks++; if (rs_full !== 1'b1) begin errors++; $display("FAIL flush_refill got=%0b exp=1", rs_full); end
        rob_clear = 1;
        tick(); idle();
        checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL flush_again got=%0b exp=0", rs_full); end
    endtask

    task automatic test_rdy();
        set_dsp(OP_AND, 1, 77, 0, 1, 0, 0, 70);
        tick(); idle();
        rdy_in = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL rdy_frozen%0d got=%0b exp=0", c, RS_flag); end
        end
        rdy_in = 1;
        tick();
        checks++; if (RS_flag !== 1'b1 || RS_V1 !== 32'd77 || RS_inst_rob_id !== 32'd70)
            begin errors++; $display("FAIL rdy_resume got flag=%0b v1=%0d rob=%0d exp 1/77/70", RS_flag, RS_V1, RS_inst_rob_id); end
        tick();
    endtask

    task automatic test_age();
        logic [31:0] first_rob, second_rob;
`ifdef ALU_RS_AGE_SELECT_EN
        first_rob = 61; second_rob = 62;
`else
        first_rob = 62; second_rob = 61;
`endif
        set_dsp(OP_ADD, 0, 0, 5, 1, 0, 0, 60);
        tick();
        set_dsp(OP_ADD, 0, 0, 3, 1, 0, 0, 61);
        tick(); idle();
        ex_cdb_flag = 1; ex_cdb_rob_id = 5; ex_cdb_val = 1;
        tick(); idle(); tick();
        checks++; if (RS_flag !== 1'b1 || RS_inst_rob_id !== 32'd60)
            begin errors++; $display("FAIL age_first_p got flag=%0b rob=%0d exp 1/60", RS_flag, RS_inst_rob_id); end
        set_dsp(OP_ADD, 0, 0, 3, 1, 0, 0, 62);
        tick(); idle();
        ex_cdb_flag = 1; ex_cdb_rob_id = 3; ex_cdb_val = 33;
        tick(); idle(); tick();
        checks++; if (RS_flag !== 1'b1 || RS_inst_rob_id !== first_rob || RS_V1 !== 32'd33)
            begin errors++; $display("FAIL age_order1 got flag=%0b rob=%0d v1=%0d exp 1/%0d/33", RS_flag, RS_inst_rob_id, RS_V1, first_rob); end
        tick();
        checks++; if (RS_flag !== 1'b1 || RS_inst_rob_id !== second_rob || RS_V1 !== 32'd33)
            begin errors++; $display("FAIL age_order2 got flag=%0b rob=%0d v1=%0d exp 1/%0d/33", RS_flag, RS_inst_rob_id, RS_V1, second_rob); end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) begin
            set_dsp(OP_SLT, 0, 0, 13, 1, 0, 0, 80 + i);
            tick();
        end
        idle();
        checks++; if (rs_full !== 1'b1) begin errors++; $display("FAIL areset_pre got=%0b exp=1", rs_full); end
        #2 rst_in = 1;
        #1;
        checks++; if (rs_full !== 1'b0 || RS_inst_rob_id !== 32'd0) begin errors++; $display("FAIL areset_now got full=%0b rob=%0d exp 0/0", rs_full, RS_inst_rob_id); end
        tick();
        rst_in = 0;
        lsb_cdb_flag = 1; lsb_cdb_rob_id = 13; lsb_cdb_val = 5;
        tick(); idle(); tick();
        checks++; if (RS_flag !== 1'b0) begin errors++; $display("FAIL areset_gone got=%0b exp=0", RS_flag); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_forward();
        test_full();
        test_flush();
        test_rdy();
        test_age();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
